// File: rtl/bbcd_pkg.sv
// bbcd_pkg: shared definitions for the binary-to-BCD peripheral arbiter.
//   - peripheral register offsets (byte addresses on the 6-bit bus)
//   - sequencer FSM state encoding
//   - largest operand the peripheral can convert
package bbcd_pkg;

    localparam logic [5:0] OPA  = 6'h04;
    localparam logic [5:0] INIT = 6'h08;
    localparam logic [5:0] UNIT = 6'h0C;
    localparam logic [5:0] DEC  = 6'h10;
    localparam logic [5:0] CENT = 6'h14;
    localparam logic [5:0] MIL  = 6'h18;
    localparam logic [5:0] DONE = 6'h1C;

    localparam int BCD_MAX = 9999;

    typedef enum logic [3:0] {
        IDLE,
        GRANT,
        WR_OPA,
        WR_INIT1,
        WR_INIT0,
        POLL_RD,
        POLL_CAP,
        DIG_RD,
        DIG_CAP,
        RESP
    } state_t;

endpackage

// File: rtl/bbcd_rr_pick.sv
// bbcd_rr_pick: combinational round-robin selector.
//   req   : request vector
//   ptr   : index with highest priority this round
//   grant : one-hot of the chosen requester
//   index : binary index of the chosen requester
//   valid : at least one request present
// The chosen requester is the first set bit at or after ptr, wrapping.
module bbcd_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int PW      = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PW-1:0]      index,
    output logic               valid
);

    always_comb begin
        grant = '0;
        index = '0;
        valid = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!valid && req[(int'(ptr) + i) % NUM_REQ]) begin
                valid                               = 1'b1;
                grant[(int'(ptr) + i) % NUM_REQ]    = 1'b1;
                index                               = PW'((int'(ptr) + i) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/bbcd_arbiter.sv
// bbcd_arbiter: shares one binary-to-BCD peripheral among NUM_REQ requesters.
// Serves one request at a time (round-robin), writes the operand, pulses
// INIT, polls DONE, reads the four digits and returns a packed BCD word
// with a one-cycle ack.
//
// Ports:
//   CLK, reset          clock (rising edge), async active-low reset
//   req, req_data       per-requester request and 16-bit binary operand
//   ack                 one-cycle completion pulse (valid in the RESP cycle)
//   rsp_bcd             {MIL,CENT,DEC,UNIT}, held until the next ack
//   rsp_ovf, rsp_err    operand > 9999 / DONE timeout, valid with ack
//   busy                transaction in progress (any state but IDLE)
//   cs, wr, rd, addr    peripheral bus strobes and register offset
//   d_in, d_out         peripheral write / read data
//
// Optional feature macro: BBCD_TIMEOUT_EN -- abort the DONE poll after
// TIMEOUT_CYCLES polls and answer with rsp_err=1. Without it the poll loop
// never gives up and rsp_err is tied low.
module bbcd_arbiter
    import bbcd_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ-1:0][15:0] req_data,
    output logic [NUM_REQ-1:0]      ack,
    output logic [15:0]             rsp_bcd,
    output logic                    rsp_ovf,
    output logic                    rsp_err,
    output logic                    busy,
    output logic                    cs,
    output logic                    wr,
    output logic                    rd,
    output logic [5:0]              addr,
    output logic [15:0]             d_in,
    input  logic [15:0]             d_out
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NUM_REQ-1:0] ONE = 1;

    state_t               state, state_nx;
    logic [PW-1:0]        ptr, idx;
    logic [15:0]          opnd;
    logic [15:0]          dig;
    logic [1:0]           k;

    logic [NUM_REQ-1:0]   pick_grant;
    logic [PW-1:0]        pick_idx;
    logic                 pick_vld;
    logic [15:0]          sel_data;
    logic                 sel_ovf;
    logic                 poll_expire;
    logic                 ld_ovf, ld_dig, ld_tmo;
    logic                 unused_bits;

    bbcd_rr_pick #(.NUM_REQ(NUM_REQ), .PW(PW)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .grant (pick_grant),
        .index (pick_idx),
        .valid (pick_vld)
    );

    assign sel_data    = req_data[pick_idx];
    assign sel_ovf     = (sel_data > 16'(BCD_MAX));
    assign busy        = (state != IDLE);
    assign unused_bits = ^{d_out[15:4], dig[15:12]};

    // Events that load the response registers and fire ack.
    assign ld_ovf = (state == GRANT) && pick_vld && sel_ovf;
    assign ld_dig = (state == DIG_CAP) && (k == 2'd3);
    assign ld_tmo = (state == POLL_CAP) && !d_out[0] && poll_expire;

`ifdef BBCD_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] poll_cnt;

    // poll_cnt holds the number of completed polls; the current POLL_CAP is
    // the last allowed one when it equals TIMEOUT_CYCLES-1.
    assign poll_expire = (poll_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            poll_cnt <= '0;
            rsp_err  <= 1'b0;
        end else begin
            if (state == WR_INIT0)
                poll_cnt <= '0;
            else if (state == POLL_CAP)
                poll_cnt <= poll_cnt + 1'b1;
            if (ld_ovf || ld_dig || ld_tmo)
                rsp_err <= ld_tmo;
        end
    end
`else
    assign poll_expire = 1'b0;
    assign rsp_err     = 1'b0;
`endif

    // State register
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (|req) state_nx = GRANT;
            GRANT: begin
                if (!pick_vld)    state_nx = IDLE;
                else if (sel_ovf) state_nx = RESP;
                else              state_nx = WR_OPA;
            end
            WR_OPA:   state_nx = WR_INIT1;
            WR_INIT1: state_nx = WR_INIT0;
            WR_INIT0: state_nx = POLL_RD;
            POLL_RD:  state_nx = POLL_CAP;
            POLL_CAP: begin
                if (d_out[0])         state_nx = DIG_RD;
                else if (poll_expire) state_nx = RESP;
                else                  state_nx = POLL_RD;
            end
            DIG_RD:   state_nx = DIG_CAP;
            DIG_CAP:  state_nx = (k == 2'd3) ? RESP : DIG_RD;
            RESP:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // Bus drivers: decoded straight from the state register so the strobes
    // drop together with the asynchronous reset.
    always_comb begin
        cs   = 1'b0;
        wr   = 1'b0;
        rd   = 1'b0;
        addr = '0;
        d_in = '0;
        case (state)
            WR_OPA:   begin cs = 1'b1; wr = 1'b1; addr = OPA;  d_in = opnd;   end
            WR_INIT1: begin cs = 1'b1; wr = 1'b1; addr = INIT; d_in = 16'd1;  end
            WR_INIT0: begin cs = 1'b1; wr = 1'b1; addr = INIT; d_in = 16'd0;  end
            POLL_RD:  begin cs = 1'b1; rd = 1'b1; addr = DONE;                end
            DIG_RD:   begin cs = 1'b1; rd = 1'b1; addr = UNIT + {2'b00, k, 2'b00}; end
            default:  ;
        endcase
    end

    // Operand, digit and response registers
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            ptr     <= '0;
            idx     <= '0;
            opnd    <= '0;
            dig     <= '0;
            k       <= '0;
            ack     <= '0;
            rsp_bcd <= '0;
            rsp_ovf <= 1'b0;
        end else begin
            ack <= '0;
            if (state == GRANT && pick_vld) begin
                idx  <= pick_idx;
                opnd <= sel_data;
                ptr  <= PW'((int'(pick_idx) + 1) % NUM_REQ);
                k    <= '0;
            end
            if (state == DIG_CAP) begin
                dig[{k, 2'b00} +: 4] <= d_out[3:0];
                k                    <= k + 2'd1;
            end
            if (ld_ovf) begin
                ack     <= pick_grant;
                rsp_bcd <= 16'h9999;
                rsp_ovf <= 1'b1;
            end
            if (ld_dig) begin
                ack     <= ONE << idx;
                rsp_bcd <= {d_out[3:0], dig[11:0]};
                rsp_ovf <= 1'b0;
            end
            if (ld_tmo) begin
                ack     <= ONE << idx;
                rsp_bcd <= '0;
                rsp_ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bbcd_arbiter.sv
// tb_bbcd_arbiter: self-checking bench for bbcd_arbiter with a behavioural
// peripheral model (DONE after a programmable delay, digits by arithmetic).
module tb_bbcd_arbiter;

    localparam int NUM_REQ = 2;
    localparam int TMO     = 255;

    logic                     CLK = 1'b0;
    logic                     reset = 1'b0;
    logic [NUM_REQ-1:0]       req = '0;
    logic [NUM_REQ-1:0][15:0] req_data = '0;
    logic [NUM_REQ-1:0]       ack;
    logic [15:0]              rsp_bcd;
    logic                     rsp_ovf, rsp_err, busy, cs, wr, rd;
    logic [5:0]               addr;
    logic [15:0]              d_in;
    logic [15:0]              d_out = '0;

    int pass_cnt = 0;
    int total_cnt = 0;
    int mptr = 0;          // model round-robin pointer

    // peripheral model state
    int done_delay = 40;
    bit stuck = 1'b0;
    int m_opa = 0;
    int m_timer = -1;
    bit m_done = 1'b0;
    int done_reads = 0;
    int cs_cycles = 0;

    bbcd_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(TMO)) dut (
        .CLK(CLK), .reset(reset), .req(req), .req_data(req_data), .ack(ack),
        .rsp_bcd(rsp_bcd), .rsp_ovf(rsp_ovf), .rsp_err(rsp_err), .busy(busy),
        .cs(cs), .wr(wr), .rd(rd), .addr(addr), .d_in(d_in), .d_out(d_out)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (cs) cs_cycles <= cs_cycles + 1;
        if (cs && wr && addr == 6'h04) m_opa <= int'(d_in);
        if (cs && wr && addr == 6'h08) begin
            m_done  <= 1'b0;
            m_timer <= d_in[0] ? -1 : done_delay;
        end else if (m_timer > 0) begin
            m_timer <= m_timer - 1;
        end else if (m_timer == 0) begin
            m_done  <= 1'b1;
            m_timer <= -1;
        end
        if (cs && rd) begin
            case (addr)
                6'h1C: begin
                    d_out      <= {15'b0, m_done && !stuck};
                    done_reads <= done_reads + 1;
                end
                6'h0C:   d_out <= 16'(m_opa % 10);
                6'h10:   d_out <= 16'((m_opa / 10) % 10);
                6'h14:   d_out <= 16'((m_opa / 100) % 10);
                6'h18:   d_out <= 16'((m_opa / 1000) % 10);
                default: d_out <= 16'hDEAD;
            endcase
        end else begin
            d_out <= 16'($urandom);   // garbage outside capture cycles
        end
    end

    function automatic logic [15:0] bcd_m(int v);
        if (v > 9999) return 16'h9999;
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int pick_m(logic [NUM_REQ-1:0] r, int p);
        for (int i = 0; i < NUM_REQ; i++)
            if (r[(p + i) % NUM_REQ]) return (p + i) % NUM_REQ;
        return -1;
    endfunction

    // Waits (bounded) for an ack; returns who was acked, the response and the
    // number of busy cycles seen up to and including the ack cycle. Drops the
    // served req. idx=-1 means no ack arrived, -2 means ack was not one-hot.
    task automatic serve(output int idx, output logic [15:0] bcd, output logic ovf,
                         output logic err, output int lat);
        idx = -1; bcd = '0; ovf = 1'b0; err = 1'b0; lat = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge CLK);
            if (busy) lat++;
            if (ack != '0) begin
                bcd = rsp_bcd; ovf = rsp_ovf; err = rsp_err;
                for (int i = 0; i < NUM_REQ; i++) if (ack[i]) idx = i;
                if ($countones(ack) != 1) idx = -2;
                else req[idx] = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge CLK);
        total_cnt++; if (ack !== '0) $display("FAIL rst_ack: got %b want 0", ack); else pass_cnt++;
        total_cnt++; if (rsp_bcd !== 16'h0) $display("FAIL rst_bcd: got %h want 0000", rsp_bcd); else pass_cnt++;
        total_cnt++;
        if ({rsp_ovf, rsp_err, busy, cs, wr, rd, addr, d_in} !== '0)
            $display("FAIL rst_outs: got %b want all 0", {rsp_ovf, rsp_err, busy, cs, wr, rd, addr, d_in});
        else pass_cnt++;
        reset = 1'b1;
        repeat (3) @(negedge CLK);
        total_cnt++; if ({busy, cs} !== 2'b00) $display("FAIL idle_no_req: got %b want 00", {busy, cs}); else pass_cnt++;
    endtask

    task automatic test_single();
        int idx, lat, r0; logic [15:0] b; logic o, e;
        req_data[0] = 16'd1234; done_delay = 40; r0 = done_reads;
        req[0] = 1'b1;
        serve(idx, b, o, e, lat);
        total_cnt++; if (idx !== 0) $display("FAIL single_idx: got %0d want 0", idx); else pass_cnt++;
        total_cnt++; if (b !== 16'h1234) $display("FAIL single_bcd: got %h want 1234", b); else pass_cnt++;
        total_cnt++; if ({o, e} !== 2'b00) $display("FAIL single_flags: got %b want 00", {o, e}); else pass_cnt++;
        total_cnt++;
        if (done_reads - r0 < 1 || lat !== 13 + 2 * (done_reads - r0))
            $display("FAIL single_lat: got %0d want %0d", lat, 13 + 2 * (done_reads - r0));
        else pass_cnt++;
        @(negedge CLK);
        total_cnt++; if (ack !== '0) $display("FAIL single_ack_pulse: got %b want 0", ack); else pass_cnt++;
        total_cnt++; if (rsp_bcd !== 16'h1234) $display("FAIL single_hold: got %h want 1234", rsp_bcd); else pass_cnt++;
        mptr = 1;
    endtask

    task automatic test_overflow();
        int idx, lat, c0; logic [15:0] b; logic o, e;
        req_data[1] = 16'd10000; c0 = cs_cycles;
        req[1] = 1'b1;
        serve(idx, b, o, e, lat);
        @(negedge CLK);
        total_cnt++; if (idx !== 1) $display("FAIL ovf_idx: got %0d want 1", idx); else pass_cnt++;
        total_cnt++; if (b !== 16'h9999) $display("FAIL ovf_bcd: got %h want 9999", b); else pass_cnt++;
        total_cnt++; if ({o, e} !== 2'b10) $display("FAIL ovf_flags: got %b want 10", {o, e}); else pass_cnt++;
        total_cnt++; if (lat !== 2) $display("FAIL ovf_lat: got %0d want 2", lat); else pass_cnt++;
        total_cnt++; if (cs_cycles !== c0) $display("FAIL ovf_no_cs: got %0d cs cycles want 0", cs_cycles - c0); else pass_cnt++;
        mptr = 0;
    endtask

    // Asserts the given mask with the given data and serves every bit,
    // checking arbitration order against the model pointer.
    task automatic test_pair(input logic [NUM_REQ-1:0] m, input int v0, input int v1, input string nm);
        int idx, lat, exp, r0; logic [15:0] b; logic o, e;
        req_data[0] = 16'(v0); req_data[1] = 16'(v1); done_delay = $urandom_range(0, 20);
        req = m;
        for (int n = 0; n < NUM_REQ && req != '0; n++) begin
            exp = pick_m(req, mptr); r0 = done_reads;
            serve(idx, b, o, e, lat);
            total_cnt++; if (idx !== exp) $display("FAIL %s_idx: got %0d want %0d", nm, idx, exp); else pass_cnt++;
            total_cnt++;
            if (b !== bcd_m(int'(req_data[exp])) || o !== (req_data[exp] > 16'd9999) || e !== 1'b0)
                $display("FAIL %s_rsp: got %h/%b/%b want %h", nm, b, o, e, bcd_m(int'(req_data[exp])));
            else pass_cnt++;
            mptr = (exp + 1) % NUM_REQ;
            if (idx < 0) begin req = '0; break; end
        end
    endtask

    task automatic test_req_drop();
        int idx, lat; logic [15:0] b; logic o, e; bit seen;
        req_data[0] = 16'd300; done_delay = 5; seen = 1'b0;
        req[0] = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge CLK);
            if (cs) begin seen = 1'b1; break; end
        end
        req[0] = 1'b0;
        serve(idx, b, o, e, lat);
        total_cnt++; if (!seen || idx !== 0) $display("FAIL drop_idx: got %0d want 0", idx); else pass_cnt++;
        total_cnt++; if (b !== 16'h0300) $display("FAIL drop_bcd: got %h want 0300", b); else pass_cnt++;
        mptr = 1;
    endtask

    task automatic test_reset_mid();
        int idx, lat; logic [15:0] b; logic o, e; bit found, saw;
        req_data[0] = 16'd777; done_delay = 30; found = 1'b0; saw = 1'b0;
        req[0] = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge CLK);
            if (cs && rd && addr == 6'h1C) begin found = 1'b1; break; end
        end
        total_cnt++; if (!found) $display("FAIL mid_poll_seen: got 0 want 1"); else pass_cnt++;
        #2 reset = 1'b0;
        #1;
        total_cnt++; if ({cs, rd, busy} !== 3'b000) $display("FAIL mid_async_drop: got %b want 000", {cs, rd, busy}); else pass_cnt++;
        req = '0;
        repeat (5) begin @(negedge CLK); if (ack != '0) saw = 1'b1; end
        total_cnt++; if (saw) $display("FAIL mid_no_ack: got ack want none"); else pass_cnt++;
        reset = 1'b1; mptr = 0;
        @(negedge CLK);
        req_data[0] = 16'd56; req[0] = 1'b1;
        serve(idx, b, o, e, lat);
        total_cnt++; if (idx !== 0 || b !== 16'h0056) $display("FAIL mid_after: got %0d/%h want 0/0056", idx, b); else pass_cnt++;
        mptr = 1;
    endtask

    task automatic test_random();
        int idx, lat, exp, r0, p, v; logic [15:0] b; logic o, e; logic ovf_x;
        for (int it = 0; it < 16; it++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                v = ($urandom_range(0, 5) == 0) ? int'($urandom_range(10000, 65535)) : int'($urandom_range(0, 9999));
                req_data[i] = 16'(v);
            end
            done_delay = $urandom_range(0, 20);
            req = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
            for (int n = 0; n < NUM_REQ && req != '0; n++) begin
                exp = pick_m(req, mptr); r0 = done_reads;
                ovf_x = (int'(req_data[exp]) > 9999);
                serve(idx, b, o, e, lat);
                p = done_reads - r0;
                total_cnt++; if (idx !== exp) $display("FAIL rnd_idx: got %0d want %0d", idx, exp); else pass_cnt++;
                total_cnt++;
                if (b !== bcd_m(int'(req_data[exp])) || o !== ovf_x || e !== 1'b0)
                    $display("FAIL rnd_rsp: got %h/%b/%b want %h/%b/0", b, o, e, bcd_m(int'(req_data[exp])), ovf_x);
                else pass_cnt++;
                total_cnt++;
                if (lat !== (ovf_x ? 2 : 13 + 2 * p) || (!ovf_x && p < 1))
                    $display("FAIL rnd_lat: got %0d want %0d", lat, ovf_x ? 2 : 13 + 2 * p);
                else pass_cnt++;
                mptr = (exp + 1) % NUM_REQ;
                if (idx < 0) begin req = '0; break; end
            end
        end
    endtask

`ifdef BBCD_TIMEOUT_EN
    task automatic test_timeout();
        int idx, lat, r0; logic [15:0] b; logic o, e;
        stuck = 1'b1; req_data[0] = 16'd4321; r0 = done_reads;
        req[0] = 1'b1;
        serve(idx, b, o, e, lat);
        total_cnt++; if (done_reads - r0 !== TMO) $display("FAIL tmo_reads: got %0d want %0d", done_reads - r0, TMO); else pass_cnt++;
        total_cnt++; if (idx !== 0 || b !== 16'h0 || {o, e} !== 2'b01)
            $display("FAIL tmo_rsp: got %0d/%h/%b want 0/0000/01", idx, b, {o, e});
        else pass_cnt++;
        stuck = 1'b0; mptr = 1;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_pair(2'b11, 12, 9876, "pair1");
        test_pair(2'b11, 12, 9876, "pair2");
        test_pair(2'b01, 0, 0, "bound0");
        test_pair(2'b11, 0, 9999, "bound_both");
        test_req_drop();
        test_reset_mid();
        test_random();
`ifdef BBCD_TIMEOUT_EN
        test_timeout();
`endif
        repeat (2) @(negedge CLK);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
